// File: rtl/pixel_stream_pkg.sv
// +------------------------------------------------------------------+
// | pixel_stream_pkg: shared types, palette and colour map.           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pixel_stream_pkg;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } tag_t;

`ifdef PIXEL_STREAM_PALETTE_EN
  localparam bit c_PALETTE_EN = 1'b1;
`else
  localparam bit c_PALETTE_EN = 1'b0;
`endif

  // RGB332 ramp: black through reds/greens towards white.
  localparam logic [7:0] c_PALETTE_LUT [16] = '{
    8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0,
    8'hE4, 8'hE8, 8'hEC, 8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'hFF
  };

  function automatic logic [7:0] map_pixel(input logic neg, input logic [3:0] nib);
    logic [7:0] px;
    if (neg)
      px = 8'h00;
    else if (c_PALETTE_EN)
      px = c_PALETTE_LUT[nib];
    else
      px = {nib, nib};
    return px;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with occupancy count.                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & ((r_count != c_DEPTH) | w_pop);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_out.sv
// +------------------------------------------------------------------+
// | pixel_stream_out: aligns request tags with solver data and streams|
// | 8-bit pixels to an Avalon-ST sink. Option: PIXEL_STREAM_PALETTE_EN|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pixel_stream_out
  import pixel_stream_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_req_valid,
  input  logic              in_start,
  input  logic              in_end,
  output logic              in_req_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_start,
  output logic              out_end,
  output logic [7:0]        out_data,
  output logic [15:0]       frame_count,
  output logic              sop_error
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int FW = DATA_W + 2;
  localparam logic [CW:0] c_DEPTH = (CW+1)'(FIFO_DEPTH);

  tag_t          r_tags [RD_LATENCY];
  tag_t          w_emerge;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          r_ready_en;
  logic          w_accept;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic          w_err_set;
  logic          r_open;
  logic          r_sop_error;
  logic [15:0]   r_frame_count;
  logic [FW-1:0] w_head;
  logic          w_empty;
  logic          w_pop;

  // Credit uses only registered state so out_ready never reaches in_req_ready.
  assign w_used       = {1'b0, w_count} + {1'b0, r_inflight};
  assign in_req_ready = r_ready_en & (w_used < c_DEPTH);
  assign w_accept     = in_req_valid & in_req_ready;
  assign w_emerge     = r_tags[RD_LATENCY-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_tags[i] <= '0;
      r_inflight <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_tags[0] <= '{valid: w_accept, sop: in_start, eop: in_end};
      for (int i = 1; i < RD_LATENCY; i++) r_tags[i] <= r_tags[i-1];
      r_ready_en <= 1'b1;
      case ({w_accept, w_emerge.valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= SYNC;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC:    if (w_emerge.valid && w_emerge.sop) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = SYNC;
    endcase
  end

  always_comb begin
    w_push    = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      SYNC: w_push = w_emerge.valid & w_emerge.sop;
      RUN: begin
        w_push    = w_emerge.valid;
        w_err_set = w_emerge.valid & w_emerge.sop & r_open;
      end
      default: w_push = 1'b0;
    endcase
  end

  // r_open: a frame has started and its end has not been written yet.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_open        <= 1'b0;
      r_sop_error   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_push) begin
        if (w_emerge.eop)      r_open <= 1'b0;
        else if (w_emerge.sop) r_open <= 1'b1;
      end
      if (w_err_set) r_sop_error <= 1'b1;
      if (w_pop && w_head[FW-2]) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  ({w_emerge.sop, w_emerge.eop, rd_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pop       = out_valid & out_ready;
  assign out_valid   = ~w_empty;
  assign out_start   = ~w_empty & w_head[FW-1];
  assign out_end     = ~w_empty & w_head[FW-2];
  assign out_data    = w_empty ? 8'h00 : map_pixel(w_head[DATA_W-1], w_head[3:0]);
  assign frame_count = r_frame_count;
  assign sop_error   = r_sop_error;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_out.sv
// +------------------------------------------------------------------+
// | tb_pixel_stream_out: randomized self-checking bench with a        |
// | queue-based reference model. Rev 1.0                              |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pixel_stream_out;

  localparam int L = 2;
  localparam int D = 4;

`ifdef PIXEL_STREAM_PALETTE_EN
  localparam logic [7:0] TB_LUT [16] = '{
    8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0,
    8'hE4, 8'hE8, 8'hEC, 8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'hFF
  };
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_req_valid = 1'b0;
  logic        in_start = 1'b0;
  logic        in_end = 1'b0;
  logic        in_req_ready;
  logic [3:0]  rd_data = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_start;
  logic        out_end;
  logic [7:0]  out_data;
  logic [15:0] frame_count;
  logic        sop_error;

  pixel_stream_out #(.RD_LATENCY(L), .FIFO_DEPTH(D), .DATA_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_req_valid (in_req_valid),
    .in_start     (in_start),
    .in_end       (in_end),
    .in_req_ready (in_req_ready),
    .rd_data      (rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_start    (out_start),
    .out_end      (out_end),
    .out_data     (out_data),
    .frame_count  (frame_count),
    .sop_error    (sop_error)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Solver model: returns the data of the address presented L cycles earlier.
  int         cyc = 0;
  logic [3:0] hist [8];
  logic [3:0] req_d = 4'h0;
  int         ready_mode = 0;

  always @(posedge clock) begin
    hist[cyc & 7] = req_d;
    cyc = cyc + 1;
    #1;
    rd_data = hist[(cyc - L) & 7];
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model state.
  logic [9:0]  expq [$];
  int          dropq [$];
  int          outstanding = 0;
  bit          started = 0;
  bit          mopen = 0;
  bit          merr = 0;
  logic [15:0] mfc = 16'h0;
  bit          fresh = 0;
  bit          lat_pending = 0;
  bit          saw_low = 0;
  int          start_cyc = -1000;
  int          first_sop_cyc = 0;
  int          last_eop_cyc = 0;

  function automatic logic [7:0] exp_pix(input logic [3:0] raw);
    int v;
    v = (raw >= 4'd8) ? int'(raw) - 16 : int'(raw);
    if (v < 0) return 8'h00;
`ifdef PIXEL_STREAM_PALETTE_EN
    return TB_LUT[v];
`else
    return 8'(v * 17);
`endif
  endfunction

  task automatic model_flush();
    expq.delete();
    dropq.delete();
    outstanding = 0;
    started = 0;
    mopen = 0;
    merr = 0;
    mfc = 16'h0;
  endtask

  always @(negedge clock) begin
    logic [9:0] h;
    if (reset_n) begin
      while (dropq.size() > 0 && dropq[0] < cyc) begin
        void'(dropq.pop_front());
        outstanding--;
      end
      chk("in_req_ready", in_req_ready, (!fresh && outstanding < D));
      if (!in_req_ready) saw_low = 1;
      fresh = 0;
      chk("frame_count", frame_count, mfc);
      if (out_valid) begin
        if (lat_pending) begin
          chk("latency", cyc - start_cyc, L + 1);
          lat_pending = 0;
        end
        if (expq.size() == 0)
          chk("spurious_valid", out_valid, 1'b0);
        else begin
          chk("beat", {out_start, out_end, out_data}, expq[0]);
          if (out_ready) begin
            h = expq.pop_front();
            outstanding--;
            if (h[9]) first_sop_cyc = cyc;
            if (h[8]) begin
              last_eop_cyc = cyc;
              mfc = mfc + 16'd1;
            end
          end
        end
      end
      if (in_req_valid && in_req_ready) begin
        outstanding++;
        if (!started && !in_start) begin
          dropq.push_back(cyc + L);
        end else begin
          if (!started) begin
            started = 1;
            start_cyc = cyc;
          end else if (in_start && mopen) begin
            merr = 1;
          end
          mopen = in_end ? 1'b0 : (in_start ? 1'b1 : mopen);
          expq.push_back({in_start, in_end, exp_pix(req_d)});
        end
      end
    end
  end

  task automatic send_beat(input bit s, input bit e, input logic [3:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_req_valid = 1'b1;
    in_start = s;
    in_end = e;
    req_d = d;
    while (!acc && n < 1000) begin
      @(negedge clock);
      acc = in_req_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_req_valid = 1'b0;
    in_start = 1'b0;
    in_end = 1'b0;
    chk("req_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_req_valid = 1'b0;
    ready_mode = 0;
    while ((expq.size() != 0 || outstanding != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    fresh = 1;
    lat_pending = 1;
    start_cyc = -1000;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) hist[i] = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_start", out_start, 1'b0);
    chk("rst_out_end", out_end, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_frame_count", frame_count, 16'h0);
    chk("rst_sop_error", sop_error, 1'b0);
    chk("rst_in_req_ready", in_req_ready, 1'b0);
    release_reset();

    // Junk before first start, then a 640-pixel frame at full rate.
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0, 4'(i + 1));
    for (int i = 0; i < 640; i++) send_beat(i == 0, i == 639, 4'(i % 8));
    drain();
    chk("t1_frame_count", frame_count, 16'd1);
    chk("t1_sop_error", sop_error, merr);
    chk("t1_throughput", last_eop_cyc - first_sop_cyc, 639);

    // Backpressure pattern 1,0,0,1 with random data.
    saw_low = 0;
    ready_mode = 1;
    for (int i = 0; i < 200; i++) send_beat(i == 0, i == 199, 4'($urandom_range(0, 15)));
    drain();
    chk("t2_frame_count", frame_count, 16'd2);
    chk("t2_credit_stall", saw_low, 1'b1);

    // Start without end at beat 100.
    for (int i = 0; i < 150; i++) send_beat(i == 0 || i == 100, i == 149, 4'($urandom_range(0, 15)));
    drain();
    chk("t4_sop_error", sop_error, merr);
    chk("t4_sop_error_set", sop_error, 1'b1);

    // Colour map corners.
    send_beat(1'b1, 1'b0, 4'hF);
    send_beat(1'b0, 1'b0, 4'h5);
    send_beat(1'b0, 1'b0, 4'h8);
    send_beat(1'b0, 1'b1, 4'h7);
    drain();
    chk("t5_sop_sticky", sop_error, 1'b1);
    chk("t5_frame_count", frame_count, mfc);

    // Fill the FIFO under stall, then reset mid-frame.
    for (int i = 0; i < 296; i++) send_beat(i == 0, 1'b0, 4'($urandom_range(0, 15)));
    ready_mode = 2;
    in_req_valid = 1'b1;
    req_d = 4'h3;
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    chk("t6_full_ready", in_req_ready, 1'b0);
    chk("t6_full_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    in_req_valid = 1'b0;
    model_flush();
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_start", out_start, 1'b0);
    chk("t6_rst_data", out_data, 8'h00);
    chk("t6_rst_frame_count", frame_count, 16'h0);
    chk("t6_rst_sop_error", sop_error, 1'b0);
    chk("t6_rst_ready", in_req_ready, 1'b0);
    ready_mode = 0;
    @(posedge clock);
    release_reset();
    send_beat(1'b0, 1'b0, 4'h1);
    send_beat(1'b0, 1'b1, 4'h2);
    for (int i = 0; i < 10; i++) send_beat(i == 0, i == 9, 4'($urandom_range(0, 15)));
    drain();
    chk("t6_frame_count", frame_count, 16'd1);
    chk("t6_sop_error", sop_error, 1'b0);

    // frame_count wrap after preload.
    @(posedge clock);
    #3;
    force dut.r_frame_count = 16'hFFFF;
    mfc = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    @(posedge clock);
    #1;
    chk("wrap_preload", frame_count, 16'hFFFF);
    send_beat(1'b1, 1'b1, 4'h2);
    drain();
    chk("wrap_zero", frame_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
